// File: rtl/application_selector_button_pio.sv
// application_selector_button_pio: Avalon-MM input PIO that synchronises, debounces and edge-captures push-buttons
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   address[1:0]          0 data (debounced level), 1 reserved, 2 interruptmask, 3 edgecapture
//   chipselect, write_n   a write happens when chipselect && !write_n (zero wait states)
//   writedata[31:0]       write data, low WIDTH bits used
//   in_port[WIDTH-1:0]    raw asynchronous button pins
//   readdata[31:0]        combinational read mux, zero-extended
//   irq                   level interrupt, |(edgecapture & interruptmask)
module application_selector_button_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit IDLE_LEVEL      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] IDLE = {WIDTH{IDLE_LEVEL}};

    logic [WIDTH-1:0] sync1, sync2, stable, stable_d;
    logic [WIDTH-1:0] mask, edge_cap, press, sel;
    logic [CW-1:0]    cnt [WIDTH];
    logic             wr_en, unused_wd;

    assign wr_en     = chipselect && !write_n;
    assign unused_wd = ^writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= IDLE;
            sync2    <= IDLE;
            stable_d <= IDLE;
        end else begin
            sync1    <= in_port;
            sync2    <= sync1;
            stable_d <= stable;
        end
    end

    // A level is accepted only after DEBOUNCE_CYCLES consecutive samples disagree with stable;
    // any agreeing sample restarts the count, so the counter never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= IDLE;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Only transitions away from the idle level count as presses.
    assign press = ~(stable_d ^ IDLE) & (stable ^ IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            mask     <= '0;
            edge_cap <= '0;
        end else begin
            if (wr_en && address == 2'd2) mask <= writedata[WIDTH-1:0];
            // press is ORed in after the clear so a simultaneous set wins
            edge_cap <= ((wr_en && address == 2'd3) ? (edge_cap & ~writedata[WIDTH-1:0]) : edge_cap) | press;
        end
    end

    always_comb begin
        sel = (address == 2'd0) ? stable :
              (address == 2'd2) ? mask :
              (address == 2'd3) ? edge_cap : '0;
        readdata = 32'(sel);
    end

    assign irq = |(edge_cap & mask);
endmodule

// File: tb/tb_application_selector_button_pio.sv
// tb_application_selector_button_pio: directed, table-driven check of the button PIO
module tb_application_selector_button_pio;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [3:0]  in_port = 4'hF;
    logic [31:0] readdata;
    logic        irq;

    int checks = 0;
    int failures = 0;

    application_selector_button_pio #(
        .WIDTH(4), .DEBOUNCE_CYCLES(4), .IDLE_LEVEL(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cs;
        logic        wn;
        logic [1:0]  wa;
        logic [31:0] wd;
        logic [1:0]  ra;
        logic [31:0] rd;
        logic        irq;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, input string nm, input logic [31:0] exp);
        address = a;
        #1;
        check(nm, readdata, exp);
    endtask

    task automatic chk_irq(input string nm, input logic exp);
        #1;
        check(nm, {31'd0, irq}, {31'd0, exp});
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n = 1'b0;
        address = a;
        writedata = d;
        tick();
        chipselect = 1'b0;
        write_n = 1'b1;
        writedata = '0;
    endtask

    initial begin
        // state entering the table: stable=E, edgecapture=1, mask=0
        vecs[0] = '{1'b1, 1'b0, 2'd2, 32'hFFFF_FFFF, 2'd2, 32'h0000_000F, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 2'd0, 32'h0000_0000, 2'd0, 32'h0000_000E, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 2'd1, 32'h0000_000F, 2'd1, 32'h0000_0000, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 2'd2, 32'h0000_0000, 2'd2, 32'h0000_000F, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 2'd3, 32'h0000_000F, 2'd3, 32'h0000_0001, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 2'd2, 32'h0000_0000, 2'd3, 32'h0000_0001, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 2'd2, 32'h0000_0001, 2'd2, 32'h0000_0001, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 2'd3, 32'h0000_0002, 2'd3, 32'h0000_0001, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 2'd3, 32'h0000_0001, 2'd3, 32'h0000_0000, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 2'd2, 32'h0000_0003, 2'd2, 32'h0000_0003, 1'b0};

        // reset
        ticks(3);
        reset = 1'b0;
        rd(2'd0, "reset_data", 32'hF);
        rd(2'd2, "reset_mask", 32'h0);
        rd(2'd3, "reset_edge", 32'h0);
        chk_irq("reset_irq", 1'b0);

        // clean press of bit 0: level visible exactly 6 edges after the change
        tick();
        in_port = 4'hE;
        address = 2'd0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 5) rd(2'd0, "press_data_k5", 32'hF);
            if (k == 6) rd(2'd0, "press_data_k6", 32'hE);
        end
        rd(2'd3, "press_edge_early", 32'h0);
        tick();
        rd(2'd3, "press_edge", 32'h1);
        chk_irq("press_irq_masked", 1'b0);

        // bounce on bit 1: two 3-cycle lows split by a 1-cycle high never qualify
        in_port = 4'hC; ticks(3);
        in_port = 4'hE; ticks(1);
        in_port = 4'hC; ticks(3);
        in_port = 4'hE; ticks(8);
        rd(2'd0, "bounce_data", 32'hE);
        rd(2'd3, "bounce_edge", 32'h1);
        chk_irq("bounce_irq", 1'b0);

        // register access table
        for (int v = 0; v < 10; v++) begin
            chipselect = vecs[v].cs;
            write_n = vecs[v].wn;
            address = vecs[v].wa;
            writedata = vecs[v].wd;
            tick();
            chipselect = 1'b0;
            write_n = 1'b1;
            writedata = '0;
            rd(vecs[v].ra, $sformatf("vec%0d_rd", v), vecs[v].rd);
            chk_irq($sformatf("vec%0d_irq", v), vecs[v].irq);
        end

        // unmasked press of bit 1 raises irq, W1C clears it, release is not captured
        in_port = 4'hC; ticks(7);
        rd(2'd0, "irq_press_data", 32'hC);
        rd(2'd3, "irq_press_edge", 32'h2);
        chk_irq("irq_press_irq", 1'b1);
        wr(2'd3, 32'h2);
        rd(2'd3, "irq_clear_edge", 32'h0);
        chk_irq("irq_clear_irq", 1'b0);
        in_port = 4'hE; ticks(10);
        rd(2'd0, "release_data", 32'hE);
        rd(2'd3, "release_edge", 32'h0);
        chk_irq("release_irq", 1'b0);

        // set/clear collision on bit 2
        in_port = 4'hA; ticks(6);
        rd(2'd0, "coll_data", 32'hA);
        rd(2'd3, "coll_edge_before", 32'h0);
        wr(2'd3, 32'hF);
        rd(2'd3, "coll_edge", 32'h4);
        chk_irq("coll_irq", 1'b0);

        // build edgecapture=5 by re-pressing bit 0
        in_port = 4'hB; ticks(7);
        rd(2'd0, "rep_release_data", 32'hB);
        in_port = 4'hA; ticks(7);
        rd(2'd3, "rep_edge", 32'h5);
        chk_irq("rep_irq", 1'b1);

        // reset while bit 3 debounce count is at 2
        in_port = 4'h2; ticks(4);
        reset = 1'b1; tick();
        reset = 1'b0;
        rd(2'd0, "mid_reset_data", 32'hF);
        rd(2'd2, "mid_reset_mask", 32'h0);
        rd(2'd3, "mid_reset_edge", 32'h0);
        chk_irq("mid_reset_irq", 1'b0);
        address = 2'd0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 5) rd(2'd0, "reaccept_k5", 32'hF);
            if (k == 6) rd(2'd0, "reaccept_k6", 32'h2);
        end
        tick();
        rd(2'd3, "reaccept_edge", 32'hD);
        chk_irq("reaccept_irq", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
